// File: rtl/decode_writeback.sv
// Y86-64 decode stage with the 15x64 register file: picks register IDs, reads operands
// through the e/M/W forwarding chain and loads the E pipeline register.
module decode_writeback #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RRSP  = 4'h4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic        E_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB
);

    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] regs [0:14];

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        dst_e  = RNONE;
        dst_m  = RNONE;
        case (D_icode)
            4'h2: begin d_srcA = D_rA; dst_e = D_rB; end
            4'h3: dst_e = D_rB;
            4'h4: begin d_srcA = D_rA; d_srcB = D_rB; end
            4'h5: begin d_srcB = D_rB; dst_m = D_rA; end
            4'h6: begin d_srcA = D_rA; d_srcB = D_rB; dst_e = D_rB; end
            4'h8: begin d_srcB = RRSP; dst_e = RRSP; end
            4'h9: begin d_srcA = RRSP; d_srcB = RRSP; dst_e = RRSP; end
            4'hA: begin d_srcA = D_rA; d_srcB = RRSP; dst_e = RRSP; end
            4'hB: begin d_srcA = RRSP; d_srcB = RRSP; dst_e = RRSP; dst_m = D_rA; end
            default: ;
        endcase
    end

    // Youngest producer wins; the W entries cover a regfile write landing this same edge.
    function automatic logic [63:0] read_fwd(input logic [3:0] src);
        if (src == RNONE)       return 64'd0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return regs[src];
    endfunction

    always_comb begin
        val_a = read_fwd(d_srcA);
        val_b = read_fwd(d_srcB);
        if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
    end

    // Port M is written after port E so it wins when both target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs[i] <= '0;
        end else begin
            if (W_dstE != RNONE) regs[W_dstE] <= W_valE;
            if (W_dstM != RNONE) regs[W_dstM] <= W_valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || E_bubble) begin
            E_stat  <= 4'b1000;
            E_icode <= 4'h1;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else begin
            E_stat  <= D_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= val_a;
            E_valB  <= val_b;
            E_dstE  <= dst_e;
            E_dstM  <= dst_m;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed program snippets with literal expectations plus
// randomized traffic compared every cycle against a table-driven model of the stage.
module tb_decode_writeback;

    typedef struct packed {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] valc, vala, valb;
        logic [3:0]  dste, dstm, srca, srcb;
    } e_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  D_stat = 4'b1000, D_icode = 4'h1, D_ifun = 4'h0, D_rA = 4'hF, D_rB = 4'hF;
    logic [63:0] D_valC = '0, D_valP = '0;
    logic        E_bubble = 1'b0;
    logic [3:0]  e_dstE = 4'hF, M_dstE = 4'hF, M_dstM = 4'hF, W_dstE = 4'hF, W_dstM = 4'hF;
    logic [63:0] e_valE = '0, M_valE = '0, m_valM = '0, W_valE = '0, W_valM = '0;
    logic [3:0]  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    logic [63:0] rf_m [15];
    int checks = 0;
    int errors = 0;

    decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic e_t bubble_e();
        e_t b;
        b = '{stat: 4'b1000, icode: 4'h1, ifun: 4'h0, valc: 64'd0, vala: 64'd0, valb: 64'd0,
              dste: 4'hF, dstm: 4'hF, srca: 4'hF, srcb: 4'hF};
        return b;
    endfunction

    function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] src);
        logic [3:0]  fd [5];
        logic [63:0] fv [5];
        fd = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        fv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == 4'hF) return 64'd0;
        for (int k = 0; k < 5; k++)
            if (fd[k] == src) return fv[k];
        return rf_m[src];
    endfunction

    function automatic e_t model_e();
        e_t r;
        if (!rst_n || E_bubble) return bubble_e();
        r.stat  = D_stat;
        r.icode = D_icode;
        r.ifun  = D_ifun;
        r.valc  = D_valC;
        r.srca  = m_srca(D_icode, D_rA);
        r.srcb  = m_srcb(D_icode, D_rB);
        r.dste  = m_dste(D_icode, D_rB);
        r.dstm  = (D_icode inside {4'h5, 4'hB}) ? D_rA : 4'hF;
        r.vala  = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_read(r.srca);
        r.valb  = m_read(r.srcb);
        return r;
    endfunction

    task automatic cmp_e(input e_t x);
        chk("E_stat", E_stat, x.stat);
        chk("E_icode", E_icode, x.icode);
        chk("E_ifun", E_ifun, x.ifun);
        chk("E_valC", E_valC, x.valc);
        chk("E_valA", E_valA, x.vala);
        chk("E_valB", E_valB, x.valb);
        chk("E_dstE", E_dstE, x.dste);
        chk("E_dstM", E_dstM, x.dstm);
        chk("E_srcA", E_srcA, x.srca);
        chk("E_srcB", E_srcB, x.srcb);
    endtask

    // One clock: predict from the applied inputs, clock, then compare the E register.
    task automatic run_cycle();
        e_t x;
        #1;
        chk("d_srcA", d_srcA, m_srca(D_icode, D_rA));
        chk("d_srcB", d_srcB, m_srcb(D_icode, D_rB));
        x = model_e();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) rf_m[i] = 64'd0;
        end else begin
            if (W_dstE != 4'hF) rf_m[W_dstE] = W_valE;
            if (W_dstM != 4'hF) rf_m[W_dstM] = W_valM;
        end
        #1;
        cmp_e(x);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        D_stat = 4'b1000; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = '0; D_valP = '0; E_bubble = 1'b0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    endtask

    task automatic instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        D_stat = 4'b1000; D_icode = ic; D_ifun = 4'h0; D_rA = ra; D_rB = rb;
        D_valC = vc; D_valP = vp;
    endtask

    function automatic logic [3:0] rand_dst();
        return ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    endfunction

    task automatic randomize_inputs();
        D_stat   = 4'b0001 << $urandom_range(0, 3);
        D_icode  = 4'($urandom_range(0, 15));
        D_ifun   = 4'($urandom_range(0, 15));
        D_rA     = 4'($urandom_range(0, 15));
        D_rB     = 4'($urandom_range(0, 15));
        D_valC   = {$urandom(), $urandom()};
        D_valP   = {$urandom(), $urandom()};
        E_bubble = ($urandom_range(0, 7) == 0);
        e_dstE = rand_dst(); e_valE = {$urandom(), $urandom()};
        M_dstE = rand_dst(); M_valE = {$urandom(), $urandom()};
        M_dstM = rand_dst(); m_valM = {$urandom(), $urandom()};
        W_dstE = rand_dst(); W_valE = {$urandom(), $urandom()};
        W_dstM = rand_dst(); W_valM = {$urandom(), $urandom()};
    endtask

    initial begin
        for (int i = 0; i < 15; i++) rf_m[i] = 64'd0;

        // Reset holds the E register at bubble values.
        idle();
        instr(4'h6, 4'h1, 4'h2, 64'h55, 64'h66);
        run_cycle();
        run_cycle();
        chk("rst_icode", E_icode, 64'h1);
        chk("rst_stat", E_stat, 64'h8);
        chk("rst_dstE", E_dstE, 64'hF);
        rst_n = 1'b1;

        // Regfile reads zero right after release.
        instr(4'h6, 4'h5, 4'h6, 64'h0, 64'h0);
        run_cycle();
        chk("post_rst_valA", E_valA, 64'h0);
        chk("post_rst_valB", E_valB, 64'h0);

        // irmovq $0x10,%rbx, later written back, then addq %rbx,%rcx.
        instr(4'h3, 4'hF, 4'h3, 64'h10, 64'ha);
        run_cycle();
        chk("irmovq_dstE", E_dstE, 64'h3);
        chk("irmovq_valC", E_valC, 64'h10);
        idle();
        W_dstE = 4'h3; W_valE = 64'h10;
        run_cycle();
        idle();
        instr(4'h6, 4'h3, 4'h1, 64'h0, 64'h0);
        run_cycle();
        chk("addq_valA", E_valA, 64'h10);

        // Forward priority e > M > W.
        idle();
        instr(4'h2, 4'h2, 4'h7, 64'h0, 64'h0);
        e_dstE = 4'h2; e_valE = 64'd5;
        M_dstE = 4'h2; M_valE = 64'd7;
        W_dstE = 4'h2; W_valE = 64'd9;
        run_cycle();
        chk("fwd_e", E_valA, 64'd5);
        e_dstE = 4'hF;
        run_cycle();
        chk("fwd_M", E_valA, 64'd7);
        M_dstE = 4'hF;
        run_cycle();
        chk("fwd_W", E_valA, 64'd9);

        // Both W ports hit R4: port M wins. Then popq %rax.
        idle();
        W_dstE = 4'h4; W_valE = 64'd1;
        W_dstM = 4'h4; W_valM = 64'd2;
        run_cycle();
        idle();
        instr(4'hB, 4'h0, 4'hF, 64'h0, 64'h0);
        run_cycle();
        chk("popq_srcA", d_srcA, 64'h4);
        chk("popq_srcB", d_srcB, 64'h4);
        chk("popq_dstE", E_dstE, 64'h4);
        chk("popq_dstM", E_dstM, 64'h0);
        chk("popq_R4", E_valA, 64'd2);

        // call uses valP; a bubble on the same edge overrides it.
        instr(4'h8, 4'h3, 4'h3, 64'h100, 64'h20);
        run_cycle();
        chk("call_valA", E_valA, 64'h20);
        chk("call_srcA", E_srcA, 64'hF);
        chk("call_dstE", E_dstE, 64'h4);
        E_bubble = 1'b1;
        run_cycle();
        chk("call_bubble_icode", E_icode, 64'h1);
        E_bubble = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            run_cycle();
        end

        // Asynchronous reset between edges clears E without a clock.
        idle();
        instr(4'h6, 4'h1, 4'h2, 64'h77, 64'h0);
        run_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_icode", E_icode, 64'h1);
        chk("async_valC", E_valC, 64'h0);
        chk("async_dstE", E_dstE, 64'hF);
        chk("async_stat", E_stat, 64'h8);
        @(negedge clk);
        run_cycle();
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            randomize_inputs();
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
